// File: rtl/approx_adder_eval_ctrl.sv
// approx_adder_eval_ctrl: on-chip error-metric sequencer for an N-bit
// approximate adder. An LFSR produces operand pairs for the external adder.
// The returned sum is compared with the exact sum mod 2^N. Error count, total
// error distance and maximum error distance are accumulated over a run.
//
// Optional build macro EVAL_MAX_CAPTURE_EN adds max_a/max_b. These hold the
// operands of the sample that last strictly raised max_ed.
//
// Handshake: start is a level sampled only in IDLE. A run is accepted on that
// edge and num_tests is latched. busy and done are registered from the FSM
// state, so they trail the state by one cycle. done is a single-cycle pulse.
// fsm_state exposes the state (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3).
module approx_adder_eval_ctrl #(
  parameter int          N     = 16,
  parameter int          CNT_W = 32,
  parameter int          ACC_W = 48,
  parameter logic [31:0] SEED  = 32'hACE1_2024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tests,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  input  logic [N-1:0]     add_s,
  output logic [CNT_W-1:0] tests_run,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N-1:0]     max_ed,
  output logic [1:0]       fsm_state
`ifdef EVAL_MAX_CAPTURE_EN
  ,
  output logic [N-1:0]     max_a,
  output logic [N-1:0]     max_b
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  state_t           state;
  logic [31:0]      lfsr;
  logic [CNT_W-1:0] num_lat;

  // One right-shift Galois step of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? TAPS : 32'h0);
  endfunction

  logic [N-1:0]     exact;
  logic [N:0]       diff;
  logic [N-1:0]     ed;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] tests_next;

  // Error distance of the current sample and the next accumulator values.
  always_comb begin
    exact      = add_a + add_b;
    diff       = {1'b0, add_s} - {1'b0, exact};
    ed         = diff[N] ? (~diff[N-1:0] + N'(1)) : diff[N-1:0];
    sum_ext    = {1'b0, sum_ed} + {{(ACC_W + 1 - N){1'b0}}, ed};
    tests_next = tests_run + CNT_W'(1);
  end

  assign fsm_state = state;

  // Sequencer FSM with registered status, operand and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED;
      num_lat   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      tests_run <= '0;
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
`ifdef EVAL_MAX_CAPTURE_EN
      max_a     <= '0;
      max_b     <= '0;
`endif
    end else begin
      busy <= (state == DRIVE) || (state == SAMPLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            tests_run <= '0;
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
`ifdef EVAL_MAX_CAPTURE_EN
            max_a     <= '0;
            max_b     <= '0;
`endif
            if (num_tests != '0) begin
              add_a   <= SEED[N-1:0];
              add_b   <= SEED[N+15:16];
              lfsr    <= lfsr_step(SEED);
              num_lat <= num_tests;
              state   <= DRIVE;
            end else begin
              lfsr    <= SEED;
              state   <= DONE;
            end
          end
        end
        DRIVE: state <= SAMPLE;
        SAMPLE: begin
          tests_run <= tests_next;
          if (ed != '0) err_count <= err_count + CNT_W'(1);
          sum_ed <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
          if (ed > max_ed) begin
            max_ed <= ed;
`ifdef EVAL_MAX_CAPTURE_EN
            max_a  <= add_a;
            max_b  <= add_b;
`endif
          end
          if (tests_next == num_lat) begin
            state <= DONE;
          end else begin
            add_a <= lfsr[N-1:0];
            add_b <= lfsr[N+15:16];
            lfsr  <= lfsr_step(lfsr);
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_adder_eval_ctrl.sv
// tb_approx_adder_eval_ctrl: drives the sequencer against a behavioural adder
// stub. Results come from a reference model built on the same operand stream.
// A second instance with a 16-bit accumulator exercises sum_ed saturation.
module tb_approx_adder_eval_ctrl;

  localparam int          N    = 16;
  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] num_tests = '0;
  int          mode = 0;

  logic        busy, done, s_busy, s_done;
  logic [15:0] add_a, add_b, add_s, s_add_a, s_add_b, s_add_s;
  logic [31:0] tests_run, err_count, s_tests_run, s_err_count;
  logic [47:0] sum_ed;
  logic [15:0] s_sum_ed;
  logic [15:0] max_ed, s_max_ed;
  logic [1:0]  fsm_state, s_fsm_state;
`ifdef EVAL_MAX_CAPTURE_EN
  logic [15:0] max_a, max_b, s_max_a, s_max_b;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  // Adder under test: exact, LSB-flipped, offset by half range, or LOA-like.
  function automatic logic [15:0] stub(input int m, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    t = a + b;
    case (m)
      0:       stub = t;
      1:       stub = t ^ 16'h0001;
      2:       stub = t + 16'h8000;
      default: stub = {t[15:4], a[3:0] | b[3:0]};
    endcase
  endfunction

  assign add_s   = stub(mode, add_a, add_b);
  assign s_add_s = stub(mode, s_add_a, s_add_b);

  approx_adder_eval_ctrl #(.N(N), .CNT_W(32), .ACC_W(48), .SEED(SEED)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tests(num_tests),
    .busy(busy), .done(done), .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .tests_run(tests_run), .err_count(err_count), .sum_ed(sum_ed),
    .max_ed(max_ed), .fsm_state(fsm_state)
`ifdef EVAL_MAX_CAPTURE_EN
    , .max_a(max_a), .max_b(max_b)
`endif
  );

  approx_adder_eval_ctrl #(.N(N), .CNT_W(32), .ACC_W(16), .SEED(SEED)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tests(num_tests),
    .busy(s_busy), .done(s_done), .add_a(s_add_a), .add_b(s_add_b), .add_s(s_add_s),
    .tests_run(s_tests_run), .err_count(s_err_count), .sum_ed(s_sum_ed),
    .max_ed(s_max_ed), .fsm_state(s_fsm_state)
`ifdef EVAL_MAX_CAPTURE_EN
    , .max_a(s_max_a), .max_b(s_max_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the operand stream and apply the metric rules.
  task automatic model(input int n, input int m);
    logic [31:0] l;
    logic [15:0] a, b, s, ma, mb;
    longint ed, ex, sum, mx, err;
    l = SEED; sum = 0; mx = 0; err = 0; ma = 0; mb = 0;
    for (int i = 0; i < n; i++) begin
      a = l[15:0];
      b = l[31:16];
      l = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
      s = stub(m, a, b);
      ex = (longint'(a) + longint'(b)) % 65536;
      ed = longint'(s) - ex;
      if (ed < 0) ed = -ed;
      if (ed != 0) err++;
      sum += ed;
      if (ed > mx) begin mx = ed; ma = a; mb = b; end
    end
    exp_q.push_back(64'(n));
    exp_q.push_back(64'(err));
    exp_q.push_back(64'(sum));
    exp_q.push_back(64'(mx));
    exp_q.push_back(sum > 65535 ? 64'd65535 : 64'(sum));
    exp_q.push_back(64'(err));
    exp_q.push_back(64'(ma));
    exp_q.push_back(64'(mb));
  endtask

  // scoreboard: compare result registers against the queued expectations
  task automatic check_results(input string tag);
    logic [63:0] ma, mb;
    if (exp_q.size() < 8) begin
      check({tag, "_queue"}, 64'(exp_q.size()), 64'd8);
      return;
    end
    check({tag, "_tests_run"}, 64'(tests_run), exp_q.pop_front());
    check({tag, "_err_count"}, 64'(err_count), exp_q.pop_front());
    check({tag, "_sum_ed"}, 64'(sum_ed), exp_q.pop_front());
    check({tag, "_max_ed"}, 64'(max_ed), exp_q.pop_front());
    check({tag, "_sat_sum_ed"}, 64'(s_sum_ed), exp_q.pop_front());
    check({tag, "_sat_err_count"}, 64'(s_err_count), exp_q.pop_front());
    ma = exp_q.pop_front();
    mb = exp_q.pop_front();
`ifdef EVAL_MAX_CAPTURE_EN
    check({tag, "_max_a"}, 64'(max_a), ma);
    check({tag, "_max_b"}, 64'(max_b), mb);
`endif
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_state"}, 64'(fsm_state), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_add_a"}, 64'(add_a), 64'd0);
    check({tag, "_add_b"}, 64'(add_b), 64'd0);
    check({tag, "_tests_run"}, 64'(tests_run), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
    check({tag, "_sum_ed"}, 64'(sum_ed), 64'd0);
    check({tag, "_max_ed"}, 64'(max_ed), 64'd0);
  endtask

  // driver: one accepted start, then wait for done; optionally poke start
  // and num_tests while the run is in progress.
  task automatic run(input string tag, input int n, input int m, input bit poke);
    int lat;
    mode = m;
    num_tests = 32'(n);
    model(n, m);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    num_tests = $urandom;
    lat = -1;
    for (int j = 0; j < 2 * n + 10; j++) begin
      if (done) begin
        lat = j;
        start = 1'b0;
        break;
      end
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(1 + 2 * n));
    @(negedge clk);
    check_results(tag);
  endtask

  // cycle-exact busy/done profile for very short runs
  task automatic timing(input string tag, input int n, input int m);
    mode = m;
    num_tests = 32'(n);
    model(n, m);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j != 0) @(negedge clk);
      check($sformatf("%s_busy_c%0d", tag, j), 64'(busy), 64'(j >= 1 && j <= 2 * n));
      check($sformatf("%s_done_c%0d", tag, j), 64'(done), 64'(j == 1 + 2 * n));
    end
    check_results(tag);
  endtask

  initial begin : main
    int dones;
    bit hit;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_cleared("reset");

    timing("t1", 1, 0);
    timing("t0", 0, 1);

    run("exact100", 100, 0, 1'b0);
    run("lsb50", 50, 1, 1'b0);
    run("half10", 10, 2, 1'b0);
    run("poke20", 20, 3, 1'b1);
    run("again20", 20, 3, 1'b0);

    // abort a run with a one-cycle reset at tests_run == 7
    mode = 3;
    num_tests = 32'd20;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    hit = 1'b0;
    for (int j = 0; j < 100; j++) begin
      if (tests_run == 32'd7) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("abort_reach7", 64'(hit), 64'd1);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check_cleared("abort");
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run("after_abort", 20, 3, 1'b0);

    for (int r = 0; r < 6; r++)
      run($sformatf("rand%0d", r), $urandom_range(1, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
